// File: rtl/ring_fifo_pkg.sv
// Shared definitions for the ring FIFO: default geometry, pointer width helper
// and a status struct that downstream consumers can reuse.
package ring_fifo_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 8;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_status_t;

  // Index bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ring_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module ring_fifo_mem import ring_fifo_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the word on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: combinational, gives first-word fall-through at the top level.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with valid/ready on both sides. Pointers carry one extra
// wrap bit so that equal pointers mean empty and equal indices with differing
// wrap bits mean full. Define RING_FIFO_COUNT_EN to add the count_o occupancy
// output and its registered counter.
module ring_fifo import ring_fifo_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o
`ifdef RING_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] count_o
`endif
);

  localparam int unsigned PtrW = ptr_w(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  fifo_status_t    status;
  logic            push;
  logic            pop;

  // Flags and handshakes come only from registered pointers.
  always_comb begin
    status.empty = (wr_ptr_q == rd_ptr_q);
    status.full  = (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]) &&
                   (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);
    full_o       = status.full;
    empty_o      = status.empty;
    wr_ready_o   = !status.full;
    rd_valid_o   = !status.empty;
    push         = wr_valid_i && !status.full;
    pop          = rd_ready_i && !status.empty;
  end

  // Next pointers: wrap at 2*DEPTH through plain binary overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  // Pointer registers; reset discards all stored words at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // A push during reset must not touch storage either.
  ring_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk_i),
    .we    (push && !rst_i),
    .waddr (wr_ptr_q[PtrW-2:0]),
    .wdata (wr_data_i),
    .raddr (rd_ptr_q[PtrW-2:0]),
    .rdata (rd_data_o)
  );

`ifdef RING_FIFO_COUNT_EN
  logic [PtrW-1:0] count_q, count_d;

  // Occupancy counter: up on push only, down on pop only, else hold.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + PtrW'(1);
    end else if (pop && !push) begin
      count_d = count_q - PtrW'(1);
    end
  end

  // Counter register, cleared together with the pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
`endif

endmodule

// File: tb/tb_ring_fifo.sv
// Self-checking bench for ring_fifo: directed boundary scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_ring_fifo;

  localparam int unsigned W = 8;
  localparam int unsigned D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid;
  logic         wr_ready;
  logic [W-1:0] wr_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [W-1:0] rd_data;
  logic         full;
  logic         empty;
`ifdef RING_FIFO_COUNT_EN
  logic [$clog2(D):0] count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] model_q [$];

  always #5 clk = ~clk;

  ring_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .wr_data_i  (wr_data),
    .rd_valid_o (rd_valid),
    .rd_ready_i (rd_ready),
    .rd_data_o  (rd_data),
    .full_o     (full),
    .empty_o    (empty)
`ifdef RING_FIFO_COUNT_EN
    ,
    .count_o    (count)
`endif
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model occupancy and head word.
  task automatic check_state();
    int occ = model_q.size();
    check_bit("empty", empty, occ == 0);
    check_bit("full", full, occ == int'(D));
    check_bit("wr_ready", wr_ready, occ != int'(D));
    check_bit("rd_valid", rd_valid, occ != 0);
    if (occ != 0) begin
      n_checks++;
      assert (rd_data === model_q[0]) else begin
        n_fail++;
        $error("FAIL rd_data: observed %h expected %h", rd_data, model_q[0]);
      end
    end
`ifdef RING_FIFO_COUNT_EN
    begin
      logic [$clog2(D):0] exp_cnt;
      exp_cnt = occ[$clog2(D):0];
      n_checks++;
      assert (count === exp_cnt) else begin
        n_fail++;
        $error("FAIL count: observed %0d expected %0d", count, exp_cnt);
      end
    end
`endif
  endtask

  // One clock: drive, check pre-edge state, clock, then advance the model.
  task automatic cycle(input logic r, input logic wv, input logic [W-1:0] wd, input logic rr);
    rst      = r;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #2;
    check_state();
    @(posedge clk);
    if (r) begin
      model_q.delete();
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = rr && (model_q.size() != 0);
      do_push = wv && (model_q.size() < int'(D));
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(wd);
    end
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Idle after reset.
    repeat (5) cycle(1'b0, 1'b0, '0, 1'b0);

    // Fill 0x10..0x17, refuse 0xFF, drain in order.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, W'(8'h10 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);

    // Index wrap-around: 5 in, 5 out, then 8 in to full, then drain.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, W'(8'h20 + i), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, W'(8'h30 + i), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // Sustained push+pop at occupancy 4.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, W'(8'h40 + i), 1'b0);
    for (int i = 4; i < 24; i++) cycle(1'b0, 1'b1, W'(8'h40 + i), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // Push+pop while full, then while empty.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, W'(8'h60 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'hAA, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, 8'hBB, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Reset at occupancy 6 while pushing.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, W'(8'h70 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'hCC, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), W'($urandom),
            1'($urandom_range(0, 1)));
    end
    cycle(1'b0, 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_fifo.md
# ring_fifo

Circular-buffer FIFO with valid/ready handshakes on both sides, built from a storage array addressed by wrapping read/write pointers. It sits directly upstream of the delay-line stage: its read side produces the `data`/`enable` stream that the shift-register stage consumes, absorbing bursty producers so the delay line advances only on real samples.

## Interface
- `WIDTH`, 8, data word width in bits (≥1)
- `DEPTH`, 8, number of entries; power of two, ≥2
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_i`  in  1  reset; synchronous, active-high
- `wr_valid_i`  in  1  producer has a word on `wr_data_i`
- `wr_ready_o`  out  1  FIFO can accept a word this cycle
- `wr_data_i`  in  WIDTH  write data
- `rd_valid_o`  out  1  `rd_data_o` holds the oldest stored word
- `rd_ready_i`  in  1  consumer takes the word this cycle
- `rd_data_o`  out  WIDTH  head-of-queue data
- `full_o`  out  1  all DEPTH entries occupied
- `empty_o`  out  1  no entries occupied
- `count_o`  out  $clog2(DEPTH)+1  occupancy 0..DEPTH (only with `RING_FIFO_COUNT_EN`)

## Operation
- Push when `wr_valid_i && wr_ready_o`; pop when `rd_valid_o && rd_ready_i`.
- `wr_ready_o = !full_o`; `rd_valid_o = !empty_o`. Both depend only on registered state; there is no combinational path from inputs to outputs.
- Pointers are `$clog2(DEPTH)+1` bits wide. The low bits index the array and the MSB is the wrap bit.
  - Empty: the pointers are equal.
  - Full: the low bits are equal and the MSBs differ.
- Both pointers increment modulo 2·DEPTH, so index wrap-around from DEPTH-1 to 0 is natural binary overflow.
- A push writes `mem[wr_ptr]` and advances `wr_ptr`. A pop advances `rd_ptr`.
- `rd_data_o = mem[rd_ptr]` is an asynchronous read (first-word fall-through). It is don't-care while `rd_valid_o=0`.
- Simultaneous push and pop:
  - When neither full nor empty, both occur and occupancy is unchanged.
  - When full, the push is refused (`wr_ready_o=0`) and only the pop occurs.
  - When empty, the pop is impossible; the push occurs with no bypass.
- A push with `wr_valid_i=0` or a pop with `rd_ready_i=0` has no effect.
- Storage is not reset.
- Reset:
  - `rst_i` clears both pointers (and the count when enabled).
  - Reset mid-operation discards all contents immediately.
  - A push or pop asserted in the reset cycle is ignored.

## Timing
- Reset values:
  - `wr_ready_o=1`
  - `rd_valid_o=0`
  - `full_o=0`
  - `empty_o=1`
  - `count_o=0`
  - `rd_data_o` X/don't-care
- Write-to-read latency: a word pushed at edge N is visible with `rd_valid_o=1` after edge N (the cycle following the push cycle).
- `full_o` and `empty_o` update on the edge that performs the causing push or pop.
- Throughput: one push and one pop per cycle sustained when not at a boundary.
- Full-to-not-full: a pop at edge N raises `wr_ready_o` in cycle N+1.

## Configuration
- `RING_FIFO_COUNT_EN` defined:
  - adds output `count_o`, a registered occupancy counter;
  - increments on push-only, decrements on pop-only, holds on both or neither;
  - must always equal `wr_ptr - rd_ptr` (modulo 2·DEPTH).
- `RING_FIFO_COUNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `ring_fifo_pkg` holds:
  - a `ptr_w(depth)` function returning `$clog2(depth)+1`;
  - the default `WIDTH`/`DEPTH` constants;
  - a `fifo_status_t` struct {full, empty} for reuse by consumers.
- Sub-module `ring_fifo_mem` provides DEPTH×WIDTH storage with one synchronous write port and one asynchronous read port.
- The top level holds the pointers, flags, handshakes and the optional counter.

## Test plan
- Reset, then idle for 5 cycles → `empty_o=1`, `full_o=0`, `wr_ready_o=1`, `rd_valid_o=0`, `count_o=0`.
- Fill: with WIDTH=8, DEPTH=8, push 0x10..0x17 with `rd_ready_i=0` → `full_o=1` and `wr_ready_o=0` after the 8th push. A 9th push of 0xFF is refused. Draining then yields 0x10..0x17 in order, ending with `empty_o=1`.
- Wrap-around: push 5 words and pop 5, then push 8 → `full_o=1`, and `rd_data_o` sequence is intact across the index wrap.
- Simultaneous push/pop at occupancy 4 for 20 cycles with an incrementing pattern → `count_o` stays 4 and the output order is strictly FIFO.
- Push and pop asserted together while full → exactly one word leaves, the write is ignored, and `full_o` drops the next cycle. The same stimulus while empty → the word is stored and `rd_valid_o` rises the next cycle.
- Reset asserted at occupancy 6 while pushing → next cycle `empty_o=1` and `count_o=0`, and the word pushed during reset is not stored.
